// File: rtl/mantissa_divider_seq_if.sv
// Start/done handshake bundle between operand unpack, the mantissa divider and rounding.
// The sticky signal exists only when MANTDIV_STICKY_EN is defined.
interface mantissa_divider_seq_if #(
   parameter int MW = 24
);
   logic          start;
   logic [MW-1:0] dividend;
   logic [MW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [MW+1:0] quotient;
   logic [MW-1:0] remainder;
   logic          norm_shift;
   logic          div_by_zero;
`ifdef MANTDIV_STICKY_EN
   logic          sticky;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, norm_shift, div_by_zero, sticky
   );
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, norm_shift, div_by_zero, sticky
   );
`else
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, norm_shift, div_by_zero
   );
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, norm_shift, div_by_zero
   );
`endif
endinterface

// File: rtl/mantissa_divider_seq.sv
// Sequential restoring divider for normalised FPU mantissas: MW+3 quotient bits, one per cycle.
// Optional sticky output is enabled with MANTDIV_STICKY_EN.
module mantissa_divider_seq #(
   parameter int MW = 24
) (
   input  logic                   clk,
   input  logic                   rstn,
   mantissa_divider_seq_if.slave  bus
);
   localparam int ITER = MW + 3;
   localparam int CW   = $clog2(ITER + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE, S_DZ} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [MW:0]    prem;
   logic [MW-1:0]  dvs;
   logic           lsb;
   logic           dz;
   logic [ITER-1:0] racc;

   logic           accept;
   logic           next_bit;
   logic [MW+1:0]  ptrial;
   logic [MW:0]    pdiff;
   logic           qbit;

   logic [MW+1:0]  quotient_q;
   logic [MW-1:0]  remainder_q;
   logic           norm_shift_q;
   logic           div_by_zero_q;
   logic           done_q;

   assign accept   = (state == S_IDLE) && bus.start;
   assign next_bit = (cnt == '0) ? lsb : 1'b0;
   assign ptrial   = {prem, next_bit};
   assign qbit     = (ptrial >= {2'b00, dvs});
   // The result is below divisor whenever qbit is set, so MW+1 bits are enough.
   assign pdiff    = ptrial[MW:0] - {1'b0, dvs};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.start) state_nxt = (bus.divisor == '0) ? S_DZ : S_CALC;
         S_CALC: if (cnt == CW'(ITER - 1)) state_nxt = S_DONE;
         S_DZ:   state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // The first MW-1 quotient bits of dividend<<(MW+2) / divisor are always zero for
   // normalised operands, so the remainder starts preloaded with dividend>>1 and only
   // the last MW+3 steps are iterated.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt  <= '0;
         prem <= '0;
         dvs  <= '0;
         lsb  <= 1'b0;
         dz   <= 1'b0;
         racc <= '0;
      end else if (accept) begin
         cnt  <= '0;
         prem <= {2'b00, bus.dividend[MW-1:1]};
         dvs  <= bus.divisor;
         lsb  <= bus.dividend[0];
         dz   <= (bus.divisor == '0);
         racc <= '0;
      end else if (state == S_CALC) begin
         cnt  <= cnt + 1'b1;
         prem <= qbit ? pdiff : ptrial[MW:0];
         racc <= {racc[ITER-2:0], qbit};
      end
   end

`ifdef MANTDIV_STICKY_EN
   logic sticky_q;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         quotient_q    <= '0;
         remainder_q   <= '0;
         norm_shift_q  <= 1'b0;
         div_by_zero_q <= 1'b0;
         done_q        <= 1'b0;
`ifdef MANTDIV_STICKY_EN
         sticky_q      <= 1'b0;
`endif
      end else begin
         done_q <= (state == S_DONE);
         if (state == S_DONE) begin
            if (dz) begin
               quotient_q    <= '1;
               remainder_q   <= '0;
               norm_shift_q  <= 1'b0;
               div_by_zero_q <= 1'b1;
`ifdef MANTDIV_STICKY_EN
               sticky_q      <= 1'b0;
`endif
            end else begin
               quotient_q    <= racc[ITER-1] ? racc[ITER-1:1] : racc[MW+1:0];
               remainder_q   <= prem[MW-1:0];
               norm_shift_q  <= ~racc[ITER-1];
               div_by_zero_q <= 1'b0;
`ifdef MANTDIV_STICKY_EN
               sticky_q      <= (prem[MW-1:0] != '0) | (racc[ITER-1] & racc[0]);
`endif
            end
         end
      end
   end

   assign bus.busy        = (state != S_IDLE);
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.norm_shift  = norm_shift_q;
   assign bus.div_by_zero = div_by_zero_q;
`ifdef MANTDIV_STICKY_EN
   assign bus.sticky      = sticky_q;
`endif
endmodule

// File: tb/tb_mantissa_divider_seq.sv
// Scoreboard bench for mantissa_divider_seq at MW=24: reference results from integer division.
module tb_mantissa_divider_seq;
   localparam int MW = 24;

   typedef struct packed {
      logic [MW+1:0] q;
      logic [MW-1:0] rem;
      logic          ns;
      logic          dz;
      logic          st;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   acc_cyc = 0;
   logic [MW+1:0] last_q = '0;
   exp_t sb[$];

   mantissa_divider_seq_if #(.MW(MW)) bus ();

   mantissa_divider_seq #(.MW(MW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [MW-1:0] a, input logic [MW-1:0] b);
      exp_t        e;
      logic [63:0] num, r, rm;
      e = '0;
      if (b == 0) begin
         e.q  = '1;
         e.dz = 1'b1;
      end else begin
         num   = 64'(a) << (MW + 2);
         r     = num / 64'(b);
         rm    = num % 64'(b);
         e.ns  = ~r[MW+2];
         e.q   = r[MW+2] ? r[MW+2:1] : r[MW+1:0];
         e.rem = rm[MW-1:0];
         e.st  = (rm != 0) | (r[MW+2] & r[0]);
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rstn && bus.done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient", bus.quotient, e.q);
            check("remainder", bus.remainder, e.rem);
            check("norm_shift", bus.norm_shift, e.ns);
            check("div_by_zero", bus.div_by_zero, e.dz);
`ifdef MANTDIV_STICKY_EN
            check("sticky", bus.sticky, e.st);
`endif
            last_q = e.q;
         end
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic wait_done(input int n0, input int budget);
      for (int i = 0; i < budget && done_cnt == n0; i++) begin
         @(negedge clk);
         #1;
      end
      if (done_cnt == n0) check("done_timeout", 0, 1);
   endtask

   // Caller must be positioned between a negedge and the next posedge.
   task automatic do_op(input logic [MW-1:0] a, input logic [MW-1:0] b, input int lat);
      int n0;
      n0 = done_cnt;
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      sb.push_back(model(a, b));
      @(posedge clk);
      #1;
      acc_cyc      = cyc;
      bus.start    = 1'b0;
      bus.dividend = MW'($urandom);
      bus.divisor  = MW'($urandom);
      check("busy_after_accept", bus.busy, 1);
      check("hold_prev_result", bus.quotient, last_q);
      wait_done(n0, 60);
      if (done_cnt != n0) check("latency", done_cyc - acc_cyc, lat);
   endtask

   initial begin
      int n0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      #1;
      check("rst_quotient", bus.quotient, 0);
      check("rst_remainder", bus.remainder, 0);
      check("rst_done", bus.done, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_norm_shift", bus.norm_shift, 0);
      check("rst_div_by_zero", bus.div_by_zero, 0);
      #20;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      do_op(24'hC00000, 24'h800000, 28);
      check("c00000_q_const", bus.quotient, 26'h3000000);
      do_op(24'h800000, 24'hC00000, 28);
      check("800000_q_const", bus.quotient, 26'h2AAAAAA);
      check("800000_rem_const", bus.remainder, 24'h800000);
      do_op(24'hFFFFFF, 24'hFFFFFF, 28);
      check("ffffff_q_const", bus.quotient, 26'h2000000);
      do_op(24'hA5A5A5, 24'h000000, 2);
      check("dz_q_const", bus.quotient, 26'h3FFFFFF);
      do_op(24'h800000, 24'hFFFFFF, 28);
      do_op(24'hFFFFFF, 24'h800000, 28);
      for (int i = 0; i < 6; i++) begin
         do_op({1'b1, 23'($urandom)}, {1'b1, 23'($urandom)}, 28);
      end

      // A start pulsed while busy must be dropped.
      @(negedge clk);
      n0 = done_cnt;
      bus.dividend = 24'h9ABCDE;
      bus.divisor  = 24'hC12345;
      bus.start    = 1'b1;
      sb.push_back(model(24'h9ABCDE, 24'hC12345));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus.dividend = 24'hFFFFFF;
      bus.divisor  = 24'h800000;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(n0, 60);
      repeat (40) @(negedge clk);
      check("busy_drop_one_done", done_cnt, n0 + 1);

      // Reset in the middle of an iteration aborts with no done.
      @(negedge clk);
      bus.dividend = 24'hC00000;
      bus.divisor  = 24'h900000;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check("abort_quotient", bus.quotient, 0);
      check("abort_remainder", bus.remainder, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_div_by_zero", bus.div_by_zero, 0);
      last_q = '0;
      n0 = done_cnt;
      @(negedge clk);
      rstn = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_no_done", done_cnt, n0);

      do_op(24'hC00000, 24'h900000, 28);
      do_op(24'hB00000, 24'h000000, 2);

      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
